// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW fader: channel count, duty width,
// default counter widths, fader state encoding and the square-law
// helper used by the optional gamma output stage.
package rgbw_pkg;

  localparam int NUM_CH     = 4;
  localparam int DUTY_W     = 8;
  localparam int FRAME_BITS = 8;
  localparam int RATE_BITS  = 4;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_t;

  // Square-law correction: (v*v + 255) >> 8. The 16-bit sum peaks at
  // 65025 + 255 = 65280, so it never overflows, and 255 maps back to 255.
  function automatic duty_t gamma_sq(input duty_t v);
    logic [2*DUTY_W-1:0] sq;
    logic [2*DUTY_W-1:0] sum;
    sq  = {{DUTY_W{1'b0}}, v} * {{DUTY_W{1'b0}}, v};
    sum = sq + {{DUTY_W{1'b0}}, {DUTY_W{1'b1}}};
    return sum[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/fader_channel.sv
// One fader channel: holds its target and current duty, moves the current
// duty one LSB toward the target on each step, and drives the duty output.
// Optional macro RGBW_FADER_GAMMA_EN adds a registered square-law output
// stage; without it the duty output is the current value directly.
module fader_channel
  import rgbw_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  duty_t target_in,
  input  logic  step,
  output duty_t cur,
  output duty_t duty,
  output logic  at_target
);

  duty_t target_q;
  duty_t cur_q;
  duty_t cur_next;

  // Value the channel moves to on a step: one LSB toward the target, never past it.
  always_comb begin
    // NOTE: default assignment first so every path drives cur_next; a missing
    // else branch here would otherwise infer a latch.
    cur_next = cur_q;
    if (cur_q < target_q) begin
      cur_next = cur_q + duty_t'(1);
    end else if (cur_q > target_q) begin
      cur_next = cur_q - duty_t'(1);
    end
  end

  // Target capture on load and current-duty stepping; the top never raises
  // step together with load, so the two updates are independent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      target_q <= '0;
      cur_q    <= '0;
    end else begin
      if (load) begin
        target_q <= target_in;
      end
      if (step) begin
        cur_q <= cur_next;
      end
    end
  end

  assign cur       = cur_q;
  // True when the pending step lands exactly on the target, which is how
  // the top detects the end of a fade on the same edge as the final step.
  assign at_target = (cur_next == target_q);

`ifdef RGBW_FADER_GAMMA_EN
  duty_t duty_q;

  // Registered square-law output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= '0;
    end else begin
      duty_q <= gamma_sq(cur_q);
    end
  end

  assign duty = duty_q;
`else
  assign duty = cur_q;
`endif

endmodule

// File: rtl/rgbw_fader.sv
// RGBW fader top: frame counter matching the PWM period, rate divider,
// IDLE/FADING control and busy/done status around four fader channels.
// Optional macro RGBW_FADER_GAMMA_EN: square-law duty outputs with one extra
// register stage; busy and done are delayed by one cycle to stay aligned.
module rgbw_fader #(
  parameter int FRAME_BITS = rgbw_pkg::FRAME_BITS,
  parameter int RATE_BITS  = rgbw_pkg::RATE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           target0,
  input  logic [7:0]           target1,
  input  logic [7:0]           target2,
  input  logic [7:0]           target3,
  input  logic [RATE_BITS-1:0] rate,
  input  logic                 load,
  output logic [7:0]           duty0,
  output logic [7:0]           duty1,
  output logic [7:0]           duty2,
  output logic [7:0]           duty3,
  output logic                 busy,
  output logic                 done
);

  import rgbw_pkg::*;

  logic [FRAME_BITS-1:0] frame_cnt;
  logic                  frame_end;
  logic [RATE_BITS-1:0]  rate_q;
  logic [RATE_BITS-1:0]  rate_cnt;
  logic                  step_tick;
  logic                  ch_step;

  fade_state_t state;
  fade_state_t state_next;
  logic        done_q;
  logic        done_next;

  duty_t              tgt_in [NUM_CH];
  duty_t              cur    [NUM_CH];
  duty_t              duty   [NUM_CH];
  logic [NUM_CH-1:0]  settle;
  logic [NUM_CH-1:0]  match;
  logic               any_diff;
  logic               all_settle;

  assign tgt_in[0] = target0;
  assign tgt_in[1] = target1;
  assign tgt_in[2] = target2;
  assign tgt_in[3] = target3;

  // Free-running frame counter; its wrap marks the PWM period boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FRAME_BITS'(1);
    end
  end

  assign frame_end = &frame_cnt;
  assign step_tick = frame_end && (rate_cnt == rate_q);

  // Rate capture and frame divider; a load restarts the divider, which also
  // discards a step_tick that lands on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q   <= '0;
      rate_cnt <= '0;
    end else if (load) begin
      rate_q   <= rate;
      rate_cnt <= '0;
    end else if (frame_end) begin
      rate_cnt <= step_tick ? '0 : rate_cnt + RATE_BITS'(1);
    end
  end

  // Channels only move while fading, and never on a load edge.
  assign ch_step = step_tick && (state == FADING) && !load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fader_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .target_in (tgt_in[i]),
      .step      (ch_step),
      .cur       (cur[i]),
      .duty      (duty[i]),
      .at_target (settle[i])
    );
    assign match[i] = (tgt_in[i] == cur[i]);
  end

  assign any_diff   = ~&match;
  assign all_settle = &settle;

  // Next state and done pulse: a load either starts a fade or completes at
  // once; otherwise a fade ends on the step that lands every channel.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (load) begin
      if (any_diff) begin
        state_next = FADING;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end else if (ch_step && all_settle) begin
      state_next = IDLE;
      done_next  = 1'b1;
    end
  end

  // State register and one-cycle done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
    end
  end

`ifdef RGBW_FADER_GAMMA_EN
  logic busy_d;
  logic done_d;

  // Delay status by one cycle to match the gamma stage in the channels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_d <= 1'b0;
      done_d <= 1'b0;
    end else begin
      busy_d <= (state == FADING);
      done_d <= done_q;
    end
  end

  assign busy = busy_d;
  assign done = done_d;
`else
  assign busy = (state == FADING);
  assign done = done_q;
`endif

  assign duty0 = duty[0];
  assign duty1 = duty[1];
  assign duty2 = duty[2];
  assign duty3 = duty[3];

endmodule

// File: tb/tb_rgbw_fader.sv
// Self-checking bench for rgbw_fader: a frame/step-level reference model
// predicts duty, busy and done every cycle, alongside directed checks of
// ramp timing, mixed directions, no-op loads, retargeting, reset and
// (with RGBW_FADER_GAMMA_EN) the square-law mapping.
module tb_rgbw_fader;

`ifdef RGBW_FADER_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] target0 = '0;
  logic [7:0] target1 = '0;
  logic [7:0] target2 = '0;
  logic [7:0] target3 = '0;
  logic [3:0] rate = '0;
  logic       load = 1'b0;
  logic [7:0] duty0, duty1, duty2, duty3;
  logic       busy, done;

  rgbw_fader dut (
    .clk     (clk),
    .reset   (reset),
    .target0 (target0),
    .target1 (target1),
    .target2 (target2),
    .target3 (target3),
    .rate    (rate),
    .load    (load),
    .duty0   (duty0),
    .duty1   (duty1),
    .duty2   (duty2),
    .duty3   (duty3),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  // Reference model: current duties, targets, frames since the divider
  // restarted, position within the 256-clock frame, and a one-cycle
  // pipeline copy for the gamma build.
  int m_cur [4];
  int m_tgt [4];
  int m_rate;
  int m_frames;
  int m_pos;
  bit m_fading;
  bit m_done;
  int p_duty [4];
  bit p_busy;
  bit p_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic int g(input int v);
`ifdef RGBW_FADER_GAMMA_EN
    return (v * v + 255) / 256;
`else
    return v;
`endif
  endfunction

  function automatic logic [33:0] dut_pack();
    return {duty0, duty1, duty2, duty3, busy, done};
  endfunction

  function automatic logic [33:0] exp_pack();
    if (LAT == 1)
      return {8'(p_duty[0]), 8'(p_duty[1]), 8'(p_duty[2]), 8'(p_duty[3]), p_busy, p_done};
    return {8'(m_cur[0]), 8'(m_cur[1]), 8'(m_cur[2]), 8'(m_cur[3]), m_fading, m_done};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0; p_duty[i] = 0;
    end
    m_rate = 0; m_frames = 0; m_pos = 0;
    m_fading = 0; m_done = 0; p_busy = 0; p_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just saw.
  task automatic model_edge();
    bit frame_end;
    bit step;
    bit differ;
    bit landed;
    int tin [4];
    if (reset !== 1'b1) return;
    for (int i = 0; i < 4; i++) p_duty[i] = g(m_cur[i]);
    p_busy = m_fading;
    p_done = m_done;
    frame_end = (m_pos == 255);
    m_pos = (m_pos + 1) % 256;
    step = 0;
    if (frame_end) begin
      m_frames++;
      if (m_frames == m_rate + 1) begin
        step = 1;
        m_frames = 0;
      end
    end
    m_done = 0;
    tin[0] = target0; tin[1] = target1; tin[2] = target2; tin[3] = target3;
    if (load) begin
      differ = 0;
      for (int i = 0; i < 4; i++) begin
        m_tgt[i] = tin[i];
        if (tin[i] != m_cur[i]) differ = 1;
      end
      m_rate = rate;
      m_frames = 0;
      m_fading = differ;
      if (!differ) m_done = 1;
    end else if (step && m_fading) begin
      landed = 1;
      for (int i = 0; i < 4; i++) begin
        if (m_cur[i] < m_tgt[i]) m_cur[i]++;
        else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
        if (m_cur[i] != m_tgt[i]) landed = 0;
      end
      if (landed) begin
        m_fading = 0;
        m_done = 1;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    edges++;
    @(negedge clk);
    check("cycle", dut_pack(), exp_pack());
  endtask

  task automatic do_load(input int t0, input int t1, input int t2, input int t3, input int r);
    target0 = 8'(t0); target1 = 8'(t1); target2 = 8'(t2); target3 = 8'(t3);
    rate = 4'(r);
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done === 1'b1) begin
        at = edges;
        break;
      end
    end
    check(tag, 64'(at >= 0), 64'd1);
  endtask

  // Assert reset between edges; outputs must clear before the next clock.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset", 64'(dut_pack()), 64'd0);
    cycle();
    cycle();
    reset = 1'b1;
    edges = 0;
  endtask

  initial begin
    int at, l_edge, e1, n_done, found;
    model_reset();
    #2;
    check("reset_state", 64'(dut_pack()), 64'd0);
    cycle();
    cycle();
    reset = 1'b1;
    edges = 0;

    // Up-ramp on channel 0, one step per frame.
    do_load(4, 0, 0, 0, 0);
    while (edges < 255) cycle();
    check("pre_first_frame", 64'(duty0), 64'd0);
    cycle();
    check("first_step_256", 64'(duty0), 64'(g(1)));
    check("ramp_busy_mid", 64'(busy), 64'd1);
    wait_done("ramp_done_seen", 1500, at);
    check("ramp_done_edge", 64'(at), 64'(1024 + LAT));
    check("ramp_final", 64'(duty0), 64'(g(4)));
    check("ramp_busy_fall", 64'(busy), 64'd0);

    // Preset everything to 10, then mixed directions at rate 2.
    do_load(10, 10, 10, 10, 0);
    wait_done("preset_done_seen", 4000, at);
    do_load(12, 8, 10, 10, 2);
    l_edge = edges;
    e1 = ((l_edge / 256) + 1) * 256;
    wait_done("mixed_done_seen", 4000, at);
    check("mixed_done_edge", 64'(at), 64'(e1 + 512 + 768 + LAT));
    check("mixed_duties", 64'({duty0, duty1, duty2, duty3}),
          64'({8'(g(12)), 8'(g(8)), 8'(g(10)), 8'(g(10))}));

    // No-op load: done next cycle, never busy.
    do_load(12, 8, 10, 10, 3);
    if (LAT == 1) cycle();
    check("noop_done", 64'(done), 64'd1);
    check("noop_busy", 64'(busy), 64'd0);
    cycle();
    check("noop_pulse_end", 64'(done), 64'd0);

    // Reset in the middle of a fade.
    do_load(50, 50, 50, 50, 0);
    repeat (600) cycle();
    apply_reset();
    repeat (4) cycle();
    check("no_done_after_reset", 64'(done), 64'd0);

    // Retarget at duty 100 with the load landing on a step_tick edge.
    do_load(200, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 30000; i++) begin
      if (m_cur[0] == 100 && m_pos == 255) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("retarget_reached", 64'(found), 64'd1);
    target0 = 8'd50;
    load = 1'b1;
    cycle();
    load = 1'b0;
    check("retarget_skip", 64'(duty0), 64'(g(100)));
    repeat (256 + LAT) cycle();
    check("retarget_descend", 64'(duty0), 64'(g(99)));
    n_done = 0;
    for (int i = 0; i < 51 * 256; i++) begin
      cycle();
      if (done === 1'b1) n_done++;
    end
    check("retarget_one_done", 64'(n_done), 64'd1);
    check("retarget_final", 64'(duty0), 64'(g(50)));
    check("retarget_idle", 64'(busy), 64'd0);

    // Randomised small fades, some reloaded mid-fade.
    for (int k = 0; k < 8; k++) begin
      int t [4];
      for (int i = 0; i < 4; i++) begin
        t[i] = m_cur[i] + int'($urandom_range(0, 6)) - 3;
        if (t[i] < 0) t[i] = 0;
        if (t[i] > 255) t[i] = 255;
      end
      do_load(t[0], t[1], t[2], t[3], int'($urandom_range(0, 1)));
      repeat ($urandom_range(50, 1500)) cycle();
    end
    if (m_fading) wait_done("random_settle", 4000, at);

`ifdef RGBW_FADER_GAMMA_EN
    do_load(0, 128, 1, 0, 0);
    wait_done("gamma_done_seen", 40000, at);
    check("gamma_128", 64'(duty1), 64'd64);
    check("gamma_1", 64'(duty2), 64'd1);
    check("gamma_0", 64'(duty0), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgbw_fader.md
Name: rgbw_fader

Overview:
- Upstream stage of the 4-channel PWM generator; produces its duty0..duty3 inputs.
- Host loads four 8-bit target intensities plus a fade rate.
- Block ramps each channel's current duty toward its target by 1 LSB per step, one step every (rate+1) PWM frames of 256 clocks.
- Busy/done status lets the host sequencer chain fades.

Parameters:
- FRAME_BITS, 8, width of internal frame counter; frame length = 2^FRAME_BITS clocks, matching the PWM period.
- RATE_BITS, 4, width of rate input and frame divider.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- target0..target3  in  8 each  requested final duty per channel (R,G,B,W)
- rate  in  RATE_BITS  frames per step minus 1 (0 = step every frame)
- load  in  1  single-cycle strobe; captures target0..3 and rate
- duty0..duty3  out  8 each  registered current duty, to PWM generator
- busy  out  1  high while any channel differs from its target
- done  out  1  one-cycle pulse when a fade completes

Behaviour:
- Reset (reset=0, asynchronous): duty*=0, busy=0, done=0, target regs=0, rate_q=0, frame_cnt=0, rate_cnt=0, state=IDLE.
- Frame counter: free-runs from reset release, wraps 255->0. frame_end = (frame_cnt==255).
- Divider: on frame_end, rate_cnt increments; step_tick = frame_end && rate_cnt==rate_q; step_tick clears rate_cnt to 0.
- Load, edge N:
  - target regs <= target inputs, rate_q <= rate, rate_cnt <= 0.
  - If any new target != current duty: state=FADING, busy=1 from cycle N+1.
  - Else: state stays IDLE and done pulses at N+1.
- FADING, on step_tick: per channel, cur+1 if cur<target, cur-1 if cur>target, hold if equal. All channels update on the same edge.
- End of fade: when the updated values all equal their targets, on that same edge:
  - state=IDLE, busy=0, done=1 for exactly one cycle.
  - Final duties are visible in the same cycle as done.
- Load during FADING: accepted; the fade continues from the current duties toward the new targets.
- Load coincident with step_tick: load wins and that step is skipped; the divider restarts.
- Step_tick while IDLE: no effect.
- Arithmetic: no wrap-around. A channel never steps past its target, so duty stays within 0..255.
- Fade duration: max|Δ| × (rate+1) × 256 clocks.
- Duties change only on frame_end edges, so each value is stable for ≥256 clocks before the PWM generator samples it at its period boundary.
- Reset mid-fade: all duties return to 0 immediately; no done pulse.

Optional Feature:
- Macro: RGBW_FADER_GAMMA_EN.
- Defined:
  - Output stage applies square-law correction: duty = (cur*cur + 255) >> 8, using a 16-bit product.
  - Mapping: 0->0, 1->1, 128->64, 255->255.
  - One extra register stage; busy and done are delayed by one cycle to stay aligned with duty.
- Undefined: duty = cur with no extra latency.

Decomposition:
- Shared package rgbw_pkg:
  - Constants: NUM_CH=4, DUTY_W=8, FRAME_BITS, RATE_BITS.
  - Typedef duty_t (8-bit).
  - Fader state enum {IDLE, FADING}.
- Sub-module fader_channel, instantiated 4×:
  - Holds target and cur registers.
  - Inputs: load, step.
  - Outputs: cur and at_target.
  - Contains the ±1 comparator/step logic and the optional gamma stage.
- Top level holds the frame counter, divider, FSM and busy/done.

Test Plan:
- Reset check: hold reset=0 mid-run -> duty*=0, busy=0, done=0 asynchronously. After release, first frame_end at cycle 255.
- Up-ramp: rate=0, load target0=4, others 0 -> duty0 steps 1,2,3,4 on four consecutive frame_ends, 256 clocks apart. done pulses with duty0=4; busy falls on the same edge.
- Mixed directions with rate: preset all channels to 10, then load targets {12,8,10,10} with rate=2. Expected:
  - ch0 rises by 1 per step, ch1 falls by 1 per step, ch2/ch3 stay at 10.
  - Steps occur every 768 clocks.
  - done after 2 steps.
- No-op load: load targets equal to current duties -> busy stays 0, done pulses the next cycle.
- Retarget mid-fade: ramp 0->200, then reload target=50 when duty=100 with load coincident with step_tick. Expected:
  - No step on that edge.
  - Ramp then descends 100->50.
  - Exactly one done, at duty=50.
- Gamma (RGBW_FADER_GAMMA_EN defined): set duty inputs to 255, 128 and 1 -> outputs 255, 64 and 1. busy and done remain aligned with the delayed duty.
